mac_burst_sched: RTL and testbench

- Sequencer that owns one shared multiply-accumulate datapath (W-bit x W-bit product, ACC_W-bit accumulator) for the mac partition.
- Accepts a burst command (length, exact/approximate mode), pulls operand pairs over a valid/ready stream, accumulates, and reports the result with a done pulse.
- In approximate mode the low TRUNC product bits are forced to 0. This mirrors the error profile of the factorized mac partitions and lets the system trade accuracy per burst.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_burst_sched_if.sv | 29 ++
 rtl/mac_burst_dp.sv | 60 ++++++
 rtl/mac_burst_sched.sv | 98 +++++++++
 tb/tb_mac_burst_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac burst sequencer: datapath widths,
// saturation limit and the sequencer state encoding.
package mac_pkg;

  localparam int unsigned W      = 4;      // operand width
  localparam int unsigned ACC_W  = 12;     // accumulator width
  localparam int unsigned LEN_W  = 8;      // burst length field width
  localparam int unsigned TRUNC  = 2;      // product LSBs zeroed in approximate mode
  localparam int unsigned PROD_W = 2 * W;  // full product width

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_burst_sched_if.sv
// Command / operand-stream / result bundle of the mac burst sequencer.
//   master: burst issuer (drives start, len, approx_en, in_valid, in_a, in_b)
//   slave : sequencer    (drives in_ready, busy, done, acc_out, ovf)
interface mac_burst_sched_if;
  import mac_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             approx_en;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output start, len, approx_en, in_valid, in_a, in_b,
    input  in_ready, busy, done, acc_out, ovf
  );

  modport slave (
    input  start, len, approx_en, in_valid, in_a, in_b,
    output in_ready, busy, done, acc_out, ovf
  );

endinterface

// File: rtl/mac_burst_dp.sv
// Two-stage multiply-accumulate datapath: registered (optionally truncated)
// product, then a saturating accumulator with a sticky overflow flag.
//   clear      : zero acc/ovf and flush the product stage (burst start)
//   beat_valid : operand pair a/b is consumed this cycle
//   mode       : 1 = zero the low TRUNC product bits
//   acc, ovf   : running sum and sticky saturation flag
module mac_burst_dp
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             beat_valid,
  input  logic             mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam logic [PROD_W-1:0] TRUNC_MASK = {PROD_W{1'b1}} << TRUNC;

  logic [PROD_W-1:0] prod;
  logic              prod_v;
  logic [PROD_W-1:0] prod_full;
  logic [ACC_W:0]    sum;
  logic              over;

  // Product and saturating sum; one spare bit on the sum catches the carry.
  always_comb begin
    prod_full = PROD_W'(a) * PROD_W'(b);
    sum       = {1'b0, acc} + (ACC_W + 1)'(prod);
    over      = (sum > (ACC_W + 1)'(ACC_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      prod_v <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      prod_v <= beat_valid;
      if (beat_valid) begin
        prod <= mode ? (prod_full & TRUNC_MASK) : prod_full;
      end
      if (prod_v) begin
        acc <= over ? ACC_MAX : sum[ACC_W-1:0];
        if (over) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_burst_sched.sv
// Burst sequencer around the shared mac datapath: takes a length/mode
// command, pulls len operand pairs over valid/ready, waits for the pipeline
// to drain and pulses done with the final accumulated value.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command, operand stream and result (slave side)
module mac_burst_sched
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mac_burst_sched_if.slave bus
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining, remaining_nx;
  logic             mode, mode_nx;
  logic             pipe_v;
  logic             in_ready_q, busy_q, done_q;
  logic             beat;
  logic             clear;

  assign beat  = bus.in_valid & in_ready_q;
  assign clear = bus.start & (state == IDLE);

  // Next-state, burst counter and mode latch.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    mode_nx      = mode;
    case (state)
      IDLE: begin
        if (bus.start) begin
          remaining_nx = bus.len;
          mode_nx      = bus.approx_en;
          state_nx     = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat) begin
          remaining_nx = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nx = DRAIN;
          end
        end
      end
      // Last product still sits in stage 1 on entry; leave once it is folded in.
      DRAIN: begin
        if (!pipe_v) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State plus registered handshake/status outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      mode       <= 1'b0;
      pipe_v     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      mode       <= mode_nx;
      pipe_v     <= beat;
      in_ready_q <= (state_nx == RUN);
      busy_q     <= (state_nx != IDLE);
      done_q     <= (state_nx == DONE);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  mac_burst_dp u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .beat_valid (beat),
    .mode       (mode),
    .a          (bus.in_a),
    .b          (bus.in_b),
    .acc        (bus.acc_out),
    .ovf        (bus.ovf)
  );

endmodule

// File: tb/tb_mac_burst_sched.sv
// Scoreboard bench for mac_burst_sched: directed bursts from the test plan
// followed by random bursts, each checked against an arithmetic reference.
module tb_mac_burst_sched;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_burst_sched_if bus();

  mac_burst_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int acc;
    int ovf;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   pa[$];
  int   pb[$];
  int   pat[$];
  bit   gaps = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: total of (optionally truncated) products, clipped at the max.
  function automatic exp_t model(input bit approx);
    exp_t e;
    longint total = 0;
    for (int i = 0; i < pa.size(); i++) begin
      int p = pa[i] * pb[i];
      if (approx) p = (p / (1 << TRUNC)) * (1 << TRUNC);
      total += p;
    end
    e.ovf = (total > longint'(ACC_MAX)) ? 1 : 0;
    e.acc = e.ovf ? int'(ACC_MAX) : int'(total);
    e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t me;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("acc_out", int'(bus.acc_out), me.acc);
        chk("ovf", int'(bus.ovf), me.ovf);
        chk("done_latency", cyc, me.done_cyc);
        chk("busy_at_done", int'(bus.busy), 1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_acc_out"}, int'(bus.acc_out), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  // Issue one burst using pa/pb; abort_after>0 pulls reset after that many beats.
  task automatic run_burst(input int len, input bit approx, input int abort_after);
    exp_t e;
    int   guard;
    int   idx;
    int   budget;
    int   extra;
    bit   v;
    bit   rdy;

    e = model(approx);
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 1, 0);

    bus.start = 1'b1;
    bus.len = LEN_W'(len);
    bus.approx_en = approx;
    @(posedge clk);
    #1;
    if (len == 0) begin
      e.done_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.len = LEN_W'($urandom_range(0, 255));
    bus.approx_en = 1'($urandom_range(0, 1));
    chk("start_clears_acc", int'(bus.acc_out), 0);
    chk("start_clears_ovf", int'(bus.ovf), 0);

    idx = 0;
    budget = 0;
    while (idx < len && budget < 5000) begin
      if (pat.size() > 0) v = 1'(pat.pop_front());
      else v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_a = W'(pa[idx]);
      bus.in_b = W'(pb[idx]);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (v && rdy) begin
        idx++;
        if (idx == abort_after) begin
          @(negedge clk);
          rst_n = 1'b0;
          bus.in_valid = 1'b0;
          #1;
          check_reset_outputs("abort");
          repeat (4) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (idx == len) begin
          e.done_cyc = cyc + 2;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (budget >= 5000) chk("beat_timeout", idx, len);

    // Keep offering data: nothing more may be consumed.
    chk("in_ready_after_last", int'(bus.in_ready), 0);
    extra = 0;
    repeat (3) begin
      bus.in_valid = 1'b1;
      bus.in_a = W'($urandom_range(0, 15));
      bus.in_b = W'($urandom_range(0, 15));
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) extra++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("extra_beats", extra, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.len = '0;
    bus.approx_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Exact burst: 15 + 14 + 225 = 254.
    pa = '{3, 2, 15}; pb = '{5, 7, 15};
    run_burst(3, 1'b0, 0);
    // Approximate burst: 12 + 12 + 224 = 248.
    run_burst(3, 1'b1, 0);
    // Stalls: valid pattern 1,0,0,1,1,0,1 -> 1+4+9+16 = 30.
    pa = '{1, 2, 3, 4}; pb = '{1, 2, 3, 4};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    run_burst(4, 1'b0, 0);
    // Saturation: 20 x 225 clips at 4095.
    pa.delete(); pb.delete();
    for (int i = 0; i < 20; i++) begin pa.push_back(15); pb.push_back(15); end
    run_burst(20, 1'b0, 0);
    // Zero length right after saturation: flags cleared, immediate done.
    pa.delete(); pb.delete();
    run_burst(0, 1'b0, 0);
    // Reset mid-burst after 2 beats, then a clean 2*3 burst.
    pa = '{1, 2, 3, 4, 5}; pb = '{5, 4, 3, 2, 1};
    run_burst(5, 1'b0, 2);
    pa = '{2}; pb = '{3};
    run_burst(1, 1'b0, 0);

    // Random bursts with random stalls and modes.
    gaps = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(0, 30);
      pa.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin
        pa.push_back($urandom_range(0, 15));
        pb.push_back($urandom_range(0, 15));
      end
      run_burst(n, 1'($urandom_range(0, 1)), 0);
    end

    // Maximum length with small operands: the counter must not wrap.
    pa.delete(); pb.delete();
    for (int i = 0; i < 255; i++) begin
      pa.push_back($urandom_range(0, 3));
      pb.push_back($urandom_range(0, 3));
    end
    run_burst(255, 1'b0, 0);

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("idle_at_end", int'(bus.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
